alu_uart_interface: RTL
=======================

ALU_UART_INTERFACE -- requirements
Module: alu_uart_interface

Interface
REQ-001 SHALL have parameter NB_DATA, default 8, operand, result and UART byte width.
REQ-002 SHALL have parameter NB_OP, default 6, ALU operation code width (NB_OP <= NB_DATA).
REQ-003 SHALL have port clk  input  1  single clock for all logic, rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_rx_data  input  NB_DATA  received byte, valid while i_rx_done=1.
REQ-006 SHALL have port i_rx_done  input  1  one-cycle pulse, a byte is available on i_rx_data.
REQ-007 SHALL have port i_alu_result  input  NB_DATA  combinational result returned by the ALU, signed.
REQ-008 SHALL have port o_datoA  output  NB_DATA  registered operand A to the ALU, signed.
REQ-009 SHALL have port o_datoB  output  NB_DATA  registered operand B to the ALU, signed.
REQ-010 SHALL have port o_operation  output  NB_OP  registered operation code to the ALU.
REQ-011 SHALL have port o_alu_valid  output  1  one-cycle pulse, ALU inputs are complete and coherent.
REQ-012 SHALL have port o_tx_data  output  NB_DATA  registered result byte for the transmitter.
REQ-013 SHALL have port o_tx_start  output  1  one-cycle pulse requesting transmission of o_tx_data.
REQ-014 SHALL have port i_tx_done  input  1  one-cycle pulse, transmitter finished the byte.
REQ-015 SHALL have port o_busy  output  1  high in EXEC, SEND and WAIT_TX.
REQ-016 SHALL have port o_err  output  1  one-cycle pulse, unsupported operation code discarded.

Function
REQ-017 SHALL implement FSM states WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX; all outputs registered.
REQ-018 SHALL, in WAIT_A on i_rx_done, latch i_rx_data into o_datoA and move to WAIT_B next edge.
REQ-019 SHALL, in WAIT_B on i_rx_done, latch i_rx_data into o_datoB and move to WAIT_OP.
REQ-020 SHALL, in WAIT_OP on i_rx_done, take i_rx_data[NB_OP-1:0] as code, ignoring upper bits.
REQ-021 SHALL accept only codes 100000, 100010, 100100, 100101, 100110, 000011, 000010, 100111 (ADD, SUB, AND, OR, XOR, SRA, SRL, NOR).
REQ-022 SHALL, for a valid code, latch it into o_operation and move to EXEC next edge.
REQ-023 SHALL, for an invalid code, pulse o_err one cycle, leave o_operation unchanged, return to WAIT_A.
REQ-024 SHALL hold o_alu_valid=1 for exactly the single EXEC cycle; it is 0 in all other states.
REQ-025 SHALL capture i_alu_result into o_tx_data on the edge leaving EXEC and move to SEND.
REQ-026 SHALL hold o_tx_start=1 for exactly the single SEND cycle, then move to WAIT_TX.
REQ-027 SHALL remain in WAIT_TX until i_tx_done=1, then return to WAIT_A next edge.
REQ-028 SHALL drop i_rx_done pulses in EXEC, SEND and WAIT_TX without altering any register.
REQ-029 SHALL ignore i_tx_done outside WAIT_TX.
REQ-030 SHALL, on simultaneous i_rx_done and i_tx_done in WAIT_TX, honour i_tx_done and drop the byte.
REQ-031 SHALL keep o_datoA, o_datoB, o_operation, o_tx_data stable between their latch events.
REQ-032 SHALL give latency: op-byte i_rx_done at cycle n -> o_alu_valid at n+1 -> o_tx_start at n+2.

Reset
REQ-033 SHALL, when i_rst=1 at a rising clk edge, set state WAIT_A and all outputs to 0.
REQ-034 SHALL give i_rst priority over all other inputs in the same cycle.
REQ-035 SHALL abort any frame in progress on reset; no o_tx_start for the aborted frame.

Verification
REQ-036 SHALL cover: bytes 0x05, 0x03, 0x20, ALU model returns 0x08 -> one o_alu_valid pulse, o_tx_start one cycle later with o_tx_data=0x08.
REQ-037 SHALL cover: bytes 0x03, 0x05, 0x22, model returns 0xFE -> o_tx_data=0xFE, o_busy high until i_tx_done.
REQ-038 SHALL cover: bytes 0x01, 0x02, 0x3F -> o_err pulse, no o_alu_valid, no o_tx_start, state WAIT_A, o_operation unchanged.
REQ-039 SHALL cover: i_rx_done 0x77 in WAIT_TX, also same cycle as i_tx_done -> byte dropped, o_datoA unchanged, next frame starts clean.
REQ-040 SHALL cover: i_rst after bytes A=0x10, B=0x20 -> all outputs 0, then bytes 0x04, 0x01, 0x02 (SRL) yield a full frame with o_datoA=0x04.

Source files
------------

// File: rtl/alu_uart_interface.sv
// alu_uart_interface
// Collects two operand bytes and an operation byte from a UART receiver and
// presents them to a combinational ALU. It then returns the ALU result to a
// UART transmitter. Every output is registered, and the whole block runs on a
// single clock with a synchronous active-high reset.
module alu_uart_interface #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_datoA,
  output logic [NB_DATA-1:0] o_datoB,
  output logic [NB_OP-1:0]   o_operation,
  output logic               o_alu_valid,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_err
);

  // Supported operation codes (MIPS-style function field).
  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  // Returns 1 when the code is one of the operations the ALU supports.
  function automatic logic op_is_valid(input logic [NB_OP-1:0] code);
    logic ok;
    case (code)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SRA, OP_SRL, OP_NOR: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t             state_r;
  state_t             next_state_s;
  logic [NB_DATA-1:0] dato_a_s;
  logic [NB_DATA-1:0] dato_b_s;
  logic [NB_OP-1:0]   operation_s;
  logic [NB_DATA-1:0] tx_data_s;
  logic               alu_valid_s;
  logic               tx_start_s;
  logic               busy_s;
  logic               err_s;
  logic [NB_OP-1:0]   code_s;

  // Only the low NB_OP bits of the operation byte carry the code.
  assign code_s = i_rx_data[NB_OP-1:0];

  // Next-state logic. The next value of every output register is computed
  // here, so pulses line up exactly with the state they describe.
  always_comb begin
    next_state_s = state_r;
    dato_a_s     = o_datoA;
    dato_b_s     = o_datoB;
    operation_s  = o_operation;
    tx_data_s    = o_tx_data;
    alu_valid_s  = 1'b0;
    tx_start_s   = 1'b0;
    err_s        = 1'b0;

    case (state_r)
      WAIT_A: begin
        if (i_rx_done) begin
          dato_a_s     = i_rx_data;
          next_state_s = WAIT_B;
        end else begin
          next_state_s = WAIT_A;
        end
      end

      WAIT_B: begin
        if (i_rx_done) begin
          dato_b_s     = i_rx_data;
          next_state_s = WAIT_OP;
        end else begin
          next_state_s = WAIT_B;
        end
      end

      WAIT_OP: begin
        if (i_rx_done) begin
          if (op_is_valid(code_s)) begin
            operation_s  = code_s;
            alu_valid_s  = 1'b1;
            next_state_s = EXEC;
          end else begin
            // Unsupported code: drop the frame and keep the last good operation.
            err_s        = 1'b1;
            next_state_s = WAIT_A;
          end
        end else begin
          next_state_s = WAIT_OP;
        end
      end

      EXEC: begin
        // The ALU has seen coherent inputs for this whole cycle; capture it.
        tx_data_s    = i_alu_result;
        tx_start_s   = 1'b1;
        next_state_s = SEND;
      end

      SEND: begin
        next_state_s = WAIT_TX;
      end

      WAIT_TX: begin
        // Received bytes are ignored here. If a byte arrives in the same
        // cycle as i_tx_done, the byte is dropped and the frame completes.
        if (i_tx_done) begin
          next_state_s = WAIT_A;
        end else begin
          next_state_s = WAIT_TX;
        end
      end

      default: begin
        next_state_s = WAIT_A;
      end
    endcase

    if ((next_state_s == EXEC) || (next_state_s == SEND) || (next_state_s == WAIT_TX)) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
  end

  // State and output registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_r     <= WAIT_A;
      o_datoA     <= '0;
      o_datoB     <= '0;
      o_operation <= '0;
      o_tx_data   <= '0;
      o_alu_valid <= 1'b0;
      o_tx_start  <= 1'b0;
      o_busy      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      o_datoA     <= dato_a_s;
      o_datoB     <= dato_b_s;
      o_operation <= operation_s;
      o_tx_data   <= tx_data_s;
      o_alu_valid <= alu_valid_s;
      o_tx_start  <= tx_start_s;
      o_busy      <= busy_s;
      o_err       <= err_s;
    end
  end

endmodule
